// File: rtl/prof_log_writer.sv
// prof_log_writer: NCNT saturating 32-bit event counters whose snapshot is
// written as a single AXI4 INCR burst to the "log" buffer at 'offset'.
// Optional build macro: PROF_CLEAR_ON_SNAP_EN -- counters restart from zero
// (or 1 if their event fires in the same cycle) whenever they are snapshotted.
module prof_log_writer #(
    parameter int NCNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      offset,
    output logic             ready,
    output logic             idle,
    output logic             done,
    output logic             err,
    input  logic [NCNT-1:0]  evt,
    output logic [63:0]      awaddr,
    output logic [7:0]       awlen,
    output logic [2:0]       awsize,
    output logic [1:0]       awburst,
    output logic             awvalid,
    input  logic             awready,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic             wlast,
    output logic             wvalid,
    input  logic             wready,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
);

    localparam int IW = (NCNT > 1) ? $clog2(NCNT) : 1;

`ifdef PROF_CLEAR_ON_SNAP_EN
    localparam bit ClearOnSnap = 1'b1;
`else
    localparam bit ClearOnSnap = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} stateT;

    stateT          state;
    logic [31:0]    cnt  [NCNT];
    logic [31:0]    snap [NCNT];
    logic [IW-1:0]  beatIdx;
    logic [63:0]    addrReg;

    assign idle    = (state == IDLE);
    assign ready   = idle && start;
    assign awaddr  = addrReg;
    assign awlen   = 8'(NCNT - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign wdata   = snap[beatIdx];
    assign wstrb   = 4'hF;

    // Live event counters: saturating increment, optional restart on snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                // NOTE: non-blocking assignments keep every register update
                // in this edge based on pre-edge values, so order is irrelevant.
                if (ClearOnSnap && ready)
                    cnt[i] <= {31'd0, evt[i]};
                else if (evt[i] && cnt[i] != 32'hFFFF_FFFF)
                    cnt[i] <= cnt[i] + 32'd1;
            end
        end
    end

    // Burst FSM: snapshot, address phase, NCNT data beats, response, done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            beatIdx <= '0;
            addrReg <= '0;
            err     <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            wlast   <= 1'b0;
            bready  <= 1'b0;
            done    <= 1'b0;
            // NOTE: the snapshot buffer is small and must read as zero after
            // reset, so it is a reset flop array rather than an inferred RAM.
            for (int i = 0; i < NCNT; i++) snap[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NCNT; i++) snap[i] <= cnt[i];
                        addrReg <= offset;
                        err     <= 1'b0;
                        awvalid <= 1'b1;
                        state   <= AW;
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        beatIdx <= '0;
                        wlast   <= (NCNT == 1);
                        state   <= W;
                    end
                end
                W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= B;
                        end else begin
                            beatIdx <= beatIdx + IW'(1);
                            wlast   <= (beatIdx == IW'(NCNT - 2));
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        err    <= err | (bresp != 2'b00);
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/prof_log_writer.md
PROF_LOG_WRITER -- requirements
Module: prof_log_writer

Interface
REQ-001 SHALL have parameter NCNT, default 4: number of 32-bit event counters, legal range 1..256.
REQ-002 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: execution request from the slave control block.
REQ-005 SHALL have port offset, input, 64 bits: base address of the "log" buffer.
REQ-006 SHALL have port ready, output, 1 bit: start accepted this cycle.
REQ-007 SHALL have port idle, output, 1 bit: FSM is in IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the log write completes.
REQ-009 SHALL have port err, output, 1 bit: sticky flag for a non-OKAY write response.
REQ-010 SHALL have port evt, input, NCNT bits: event pulses; bit i increments counter i.
REQ-011 SHALL have AXI4 master write-address outputs awaddr[63:0], awlen[7:0], awsize[2:0], awburst[1:0] and awvalid, plus input awready.
REQ-012 SHALL have AXI4 master write-data outputs wdata[31:0], wstrb[3:0], wlast and wvalid, plus input wready.
REQ-013 SHALL have AXI4 master write-response inputs bresp[1:0] and bvalid, plus output bready; the block has no read channel.

Function
REQ-014 SHALL keep NCNT counters that increment by 1 in every cycle their evt bit is high and saturate at 0xFFFFFFFF.
REQ-015 SHALL implement FSM states IDLE, AW, W, B and DONE.
REQ-016 SHALL drive idle = (state == IDLE) and ready = idle && start, both combinational.
REQ-017 SHALL, on ready, snapshot all counters into a buffer, capture offset, clear err and go to AW.
REQ-018 SHALL, in AW, assert awvalid with awaddr = captured offset, awlen = NCNT-1, awsize = 3'b010 and awburst = 2'b01, holding all of them stable until awready, then go to W.
REQ-019 SHALL, in W, send beat k (k = 0..NCNT-1) with wdata = snapshot[k], wstrb = 4'hF and wlast = (k == NCNT-1), holding wvalid and data stable while wready is low.
REQ-020 SHALL go from W to B on the beat where wvalid && wready && wlast.
REQ-021 SHALL, in B, assert bready; on bvalid it SHALL set err if bresp != 2'b00, then go to DONE.
REQ-022 SHALL, in DONE, pulse done for exactly one cycle and return to IDLE.
REQ-023 SHALL meet these latencies: awvalid in cycle N+1 after ready in cycle N; minimum start-to-done is NCNT+3 cycles with zero-wait slave.
REQ-024 SHALL accept a start that is still high on return to IDLE (auto-restart) in the first IDLE cycle.
REQ-025 SHALL ignore start outside IDLE and SHALL keep ready low there.
REQ-026 SHALL never change its snapshot buffer mid-burst; evt activity during a burst updates only the live counters.
REQ-027 SHALL leave err readable until the next accepted start.

Reset
REQ-028 SHALL, while rst_n is low at a clock edge, go to IDLE and clear counters, the snapshot buffer, the beat index, err, awvalid, wvalid, wlast, bready and done; ready = start and idle = 1 after that edge.
REQ-029 SHALL abort any transaction in flight when reset is asserted mid-burst and SHALL drive no valid in the following cycle.

Configuration
REQ-030 SHALL, with macro PROF_CLEAR_ON_SNAP_EN defined, clear every counter in the snapshot cycle; a counter whose evt bit is high in that same cycle SHALL load 1.
REQ-031 SHALL, without PROF_CLEAR_ON_SNAP_EN, let the counters keep accumulating across snapshots.

Verification
REQ-032 SHALL pass: NCNT=4, evt0 pulsed 5x, evt3 pulsed 2x, offset=0x1000, start, zero-wait slave -> awaddr=0x1000, awlen=3, wdata 5,0,0,2, wlast on beat 3, done at cycle 7.
REQ-033 SHALL pass: awready delayed 3 cycles and wready low on beat 1 for 2 cycles -> awaddr, wdata and wlast held stable; done pulses once.
REQ-034 SHALL pass: bresp=2'b10 -> err=1 after done; next start -> err=0.
REQ-035 SHALL pass: start held high continuously -> back-to-back bursts, ready pulsed once per burst, idle high 1 cycle between.
REQ-036 SHALL pass: rst_n low during beat 2 -> wvalid=0 next cycle, idle=1, counters 0.
REQ-037 SHALL pass: with PROF_CLEAR_ON_SNAP_EN, evt0 high in the snapshot cycle -> counter 0 = 1 after snapshot; without the macro -> the prior count plus 1.
